// File: rtl/control_sequencer.sv
// Micro-step controller for the RA/RB/RZ adder datapath: accepts one opcode per
// start/ready handshake and issues bus-select / register-load strobes per cycle.
module control_sequencer #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   ready,
    output logic                   done,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] iter,
    output logic                   RAout,
    output logic                   RBout,
    output logic                   RZout,
    output logic                   RAin,
    output logic                   RBin,
    output logic                   RZin
);

    // Handshake: an op is accepted on a rising edge where start && ready;
    // ready is high only in IDLE with clear low, so start is ignored while busy.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP1 = 2'd1,
        STEP2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LDA   = 3'b001;
    localparam logic [2:0] OP_MOVAB = 3'b010;
    localparam logic [2:0] OP_ADDA  = 3'b011;
    localparam logic [2:0] OP_ADDB  = 3'b100;
    localparam logic [2:0] OP_ACC   = 3'b101;

    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] iter_q, iter_d;
    logic [COUNT_WIDTH:0]   iter_next;
    logic                   op_illegal;
    logic                   op_two_step;

    assign op_illegal  = op_q[2] & op_q[1];
    assign op_two_step = (op_q == OP_ADDA) || (op_q == OP_ADDB) || (op_q == OP_ACC);
    // One bit wider than iter so the loop test never sees a wrapped value.
    assign iter_next   = {1'b0, iter_q} + (COUNT_WIDTH + 1)'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            count_q <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    count_d = count;
                    iter_d  = '0;
                    if ((op == OP_NOP) || (op[2] & op[1]) ||
                        ((op == OP_ACC) && (count == '0))) begin
                        state_d = DONE;
                    end else begin
                        state_d = STEP1;
                    end
                end
            end
            STEP1: state_d = op_two_step ? STEP2 : DONE;
            STEP2: begin
                state_d = DONE;
                if (op_q == OP_ACC) begin
                    iter_d = iter_next[COUNT_WIDTH-1:0];
                    if (iter_next < {1'b0, count_q}) begin
                        state_d = STEP1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only from registered state and latched op; clear masks
    // them so an aborted op issues nothing further.
    always_comb begin
        ready   = (state_q == IDLE) && !clear;
        done    = 1'b0;
        illegal = 1'b0;
        RAout   = 1'b0;
        RBout   = 1'b0;
        RZout   = 1'b0;
        RAin    = 1'b0;
        RBin    = 1'b0;
        RZin    = 1'b0;
        if (!clear) begin
            case (state_q)
                STEP1: begin
                    case (op_q)
                        OP_LDA:   RAin = 1'b1;
                        OP_MOVAB: begin RAout = 1'b1; RBin = 1'b1; end
                        OP_ADDA:  begin RAout = 1'b1; RZin = 1'b1; end
                        OP_ADDB,
                        OP_ACC:   begin RBout = 1'b1; RZin = 1'b1; end
                        default:  ;
                    endcase
                end
                STEP2: begin
                    if (op_two_step) begin
                        RZout = 1'b1;
                        RBin  = 1'b1;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    illegal = op_illegal;
                end
                default: ;
            endcase
        end
    end

    assign iter = iter_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Micro-step controller that drives the bus-select and register-load strobes of the RA/RB/RZ adder datapath. It accepts one opcode per start/ready handshake and sequences the strobes cycle by cycle. It signals completion with a one-cycle `done` pulse. It sits between the instruction source and the datapath and is the sole driver of `RAout/RBout/RZout/RAin/RBin/RZin`.

## Interface
- `COUNT_WIDTH`, default 4: width of the ACC iteration count.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only when `ready`=1.
- `op`  in  3  opcode, sampled at acceptance.
- `count`  in  COUNT_WIDTH  ACC iteration count, sampled at acceptance.
- `ready`  out  1  idle and able to accept.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  high with `done` when the accepted op was undefined.
- `iter`  out  COUNT_WIDTH  ACC iterations completed so far.
- `RAout`, `RBout`, `RZout`  out  1 each  bus source selects; at most one high in any cycle.
- `RAin`, `RBin`, `RZin`  out  1 each  register load enables.

## Operation
- States: IDLE, STEP1, STEP2, DONE.
- Opcodes:
  - 000 NOP: no strobes.
  - 001 LDA: STEP1 asserts `RAin` (RA takes the immediate).
  - 010 MOVAB: STEP1 asserts `RAout`+`RBin`.
  - 011 ADDA: STEP1 asserts `RAout`+`RZin`; STEP2 asserts `RZout`+`RBin`. Net effect RB = A + RA.
  - 100 ADDB: STEP1 asserts `RBout`+`RZin`; STEP2 asserts `RZout`+`RBin`. Net effect RB = A + RB.
  - 101 ACC: performs ADDB `count` times.
  - 110, 111: illegal.
- Transitions:
  - IDLE goes to STEP1 on `start`, except NOP, illegal, and ACC with `count`=0, which go directly to DONE.
  - STEP1 goes to STEP2 for ADDA, ADDB and ACC; otherwise to DONE.
  - STEP2 for ACC: increment `iter`. Return to STEP1 if `iter`+1 < latched count; otherwise go to DONE. For ADDA and ADDB, go to DONE.
  - DONE always goes to IDLE.
- `ready` = (state==IDLE) && !`clear`.
- `start` is ignored outside IDLE. `op` and `count` changes after acceptance have no effect.
- `iter` clears to 0 on acceptance and holds its final value through DONE until the next acceptance.
- `illegal` is high only in the DONE cycle of an illegal op. An illegal op drives no strobes.
- All outputs decode from registered state and latched op only, with no combinational path from `start`, `op` or `count`.

## Timing
- Reset: on the first edge with `clear`=1, state goes to IDLE and latched op, count and `iter` go to 0. While `clear`=1, `ready`=0 and `done`, `illegal` and all strobes are 0.
- `clear` mid-operation aborts at the next edge. No further strobes are issued, and `done` does not pulse for the aborted op.
- If acceptance happens at edge k, the first active cycle is k+1. Latency from acceptance edge to the start of the `done` cycle:
  - NOP and illegal: 1 cycle.
  - LDA and MOVAB: 2 cycles.
  - ADDA and ADDB: 3 cycles.
  - ACC with count N: 2N+1 cycles.
- `ready` returns in the cycle after `done`. The minimum spacing between acceptances is latency+1 cycles.
- Strobes are level signals held for exactly the one STEP cycle. The datapath captures on the edge that ends that cycle.
- Counter width: `iter` never wraps. The maximum ACC is 2^COUNT_WIDTH−1 iterations.

## Test plan
- Reset during an ADDA STEP2 cycle (clear=1 for 1 cycle) -> next cycle: all strobes 0, `done`=0, `iter`=0. `ready`=1 once clear drops. No `done` pulse for the aborted op.
- LDA then ADDA, with the datapath attached, A=5 and immediate=7 -> RA=7, then RB=12. Strobes are RAin; then RAout+RZin, RZout+RBin. `done` pulses at latency 2 and 3.
- ACC with count=3, A=2, RB preloaded to 1 -> RB=7 after 6 STEP cycles. `iter` steps 1,2,3. `done` at cycle 7 after acceptance.
- ACC with count=0 -> `done` 1 cycle after acceptance, no strobes, `iter`=0.
- op=110 -> `done`=1 and `illegal`=1 together at latency 1. No strobes. `illegal`=0 in the following cycle.
- `start` held high continuously with MOVAB -> acceptances every 3 cycles. `start` is ignored while busy. Every cycle has at most one of the `*out` strobes high.
